magnetron_ctrl: RTL and testbench

Clocked, parametrised successor to the magnetron SR-latch control. Adds selectable power levels by time-proportioned duty cycling of the magnetron across a fixed window, and an explicit cook/pause/idle state machine. Sits between the front-panel button/door/timer logic and the magnetron driver in the microwave top level. Door interlock stays absolute.

---
 rtl/magnetron_pkg.sv | 9 +
 rtl/magnetron_if.sv | 18 +
 rtl/magnetron_duty_window.sv | 52 +++++
 rtl/magnetron_ctrl.sv | 46 ++++
 tb/tb_magnetron_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/magnetron_pkg.sv
// magnetron_pkg: shared state encoding, default sizing and power-level clamp for magnetron_ctrl.
package magnetron_pkg;
    typedef enum logic [1:0] {IDLE, COOK, PAUSE} state_t;
    localparam int DEF_LEVELS = 10;
    localparam int DEF_SLOT_CYCLES = 100;
    function automatic int unsigned clamp_level(int unsigned lvl, int unsigned levels);
        return lvl > levels ? levels : lvl;
    endfunction
endpackage

// File: rtl/magnetron_if.sv
// magnetron_if: front-panel/door/timer controls into magnetron_ctrl and magnetron status out of it.
interface magnetron_if
    import magnetron_pkg::*;
#(
    parameter int LW = $clog2(DEF_LEVELS + 1)
);
    logic startn, stopn, clearn, door_closed, timer_done;
    logic [LW-1:0] power_level;
    logic mag_on, cooking, paused, done;
    modport master (
        output startn, stopn, clearn, door_closed, timer_done, power_level,
        input  mag_on, cooking, paused, done
    );
    modport slave (
        input  startn, stopn, clearn, door_closed, timer_done, power_level,
        output mag_on, cooking, paused, done
    );
endinterface

// File: rtl/magnetron_duty_window.sv
// duty_window: window counter, per-window power level reload and registered on-time compare.
// MAGNETRON_SOFTSTART_EN: first window after each COOK entry runs at half the latched level.
module duty_window
    import magnetron_pkg::*;
#(
    parameter int LEVELS = DEF_LEVELS,
    parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
    localparam int LW = $clog2(LEVELS + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          run,
    input  logic          enter,
    input  logic [LW-1:0] power_level,
    output logic          mag_q
);
    localparam int WIN = LEVELS * SLOT_CYCLES;
    localparam int CW = $clog2(WIN);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] lvl_q, lvl_d, lvl_in, lvl_eff;
    logic [CW:0] on_time;
    logic wrap, mag_d;
    assign lvl_in = LW'(clamp_level(32'(power_level), LEVELS));
    assign wrap = cnt_q == CW'(WIN - 1);
    assign cnt_d = enter ? '0 : run ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
    assign lvl_d = (enter || (run && wrap)) ? lvl_in : lvl_q;
`ifdef MAGNETRON_SOFTSTART_EN
    logic first_q, first_d;
    assign first_d = enter ? 1'b1 : (run && wrap) ? 1'b0 : first_q;
    assign lvl_eff = first_d ? lvl_d >> 1 : lvl_d;
    always_ff @(posedge clk) begin
        if (!resetn) first_q <= 1'b0;
        else first_q <= first_d;
    end
`else
    assign lvl_eff = lvl_d;
`endif
    // One extra bit so full power (on_time == WIN) never wraps.
    assign on_time = (CW + 1)'(lvl_eff) * (CW + 1)'(SLOT_CYCLES);
    assign mag_d = run && ({1'b0, cnt_d} < on_time);
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
            lvl_q <= '0;
            mag_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
            mag_q <= mag_d;
        end
    end
endmodule

// File: rtl/magnetron_ctrl.sv
// magnetron_ctrl: cook/pause/idle FSM with absolute door interlock over a duty-cycled power window.
// Build option MAGNETRON_SOFTSTART_EN enables half-level first window (see duty_window).
module magnetron_ctrl
    import magnetron_pkg::*;
#(
    parameter int LEVELS = DEF_LEVELS,
    parameter int SLOT_CYCLES = DEF_SLOT_CYCLES
) (
    input logic clk,
    input logic resetn,
    magnetron_if.slave bus
);
    state_t state_q, state_d;
    logic start_ok, done_d, done_q, mag_q;
    // Start loses to every higher-priority event in the same cycle.
    assign start_ok = bus.clearn && bus.door_closed && bus.stopn && !bus.timer_done && !bus.startn;
    assign done_d = state_q == COOK && bus.clearn && bus.door_closed && bus.stopn && bus.timer_done;
    always_comb begin
        state_d = state_q;
        if (!bus.clearn) state_d = IDLE;
        else if (state_q == COOK) state_d = (!bus.door_closed || !bus.stopn) ? PAUSE : bus.timer_done ? IDLE : COOK;
        else if (state_q == PAUSE) state_d = !bus.stopn ? IDLE : start_ok ? COOK : PAUSE;
        else state_d = start_ok ? COOK : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q <= done_d;
        end
    end
    duty_window #(.LEVELS(LEVELS), .SLOT_CYCLES(SLOT_CYCLES)) u_duty (
        .clk(clk),
        .resetn(resetn),
        .run(state_d == COOK),
        .enter(state_d == COOK && state_q != COOK),
        .power_level(bus.power_level),
        .mag_q(mag_q)
    );
    assign bus.mag_on = mag_q && bus.door_closed;
    assign bus.cooking = state_q == COOK;
    assign bus.paused = state_q == PAUSE;
    assign bus.done = done_q;
endmodule

// File: tb/tb_magnetron_ctrl.sv
// tb_magnetron_ctrl: scenario tasks push expected {mag_on,cooking,paused,done} and compare each cycle.
module tb_magnetron_ctrl;
    localparam int LEVELS = 10;
    localparam int SLOT = 4;
    localparam int WIN = LEVELS * SLOT;
    logic clk = 1'b0;
    logic resetn;
    logic [3:0] sb[$];
    logic [3:0] got, want;
    int vecs = 0;
    int errs = 0;
    always #5 clk = ~clk;
    magnetron_if #(.LW(4)) bus();
    magnetron_ctrl #(.LEVELS(LEVELS), .SLOT_CYCLES(SLOT)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );
    function automatic logic [3:0] obs();
        return {bus.mag_on, bus.cooking, bus.paused, bus.done};
    endfunction
    function automatic int on_cyc(int lvl, int k);
        int l = lvl > LEVELS ? LEVELS : lvl;
`ifdef MAGNETRON_SOFTSTART_EN
        if (k < WIN) l = l / 2;
`endif
        return l * SLOT;
    endfunction
    function automatic logic [3:0] cook_exp(int lvl, int k);
        return {(k % WIN) < on_cyc(lvl, k), 3'b100};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(bit s, bit st, bit c, bit d, bit t, int lvl);
        bus.startn = s;
        bus.stopn = st;
        bus.clearn = c;
        bus.door_closed = d;
        bus.timer_done = t;
        bus.power_level = 4'(lvl);
    endtask
    task automatic cook_from_idle(string name, int lvl, int n);
        drive(0, 1, 1, 1, 0, lvl);
        for (int k = 0; k < n; k++) begin
            sb.push_back(cook_exp(lvl, k));
            tick();
            bus.startn = 1'b1;
            got = obs(); want = sb.pop_front(); vecs++;
            if (got !== want) begin errs++; $display("FAIL %s k=%0d: got %b want %b (mag,cook,paused,done)", name, k, got, want); end
        end
    endtask
    task automatic clear_to_idle(string name);
        bus.clearn = 1'b0;
        sb.push_back(4'b0000);
        tick();
        bus.clearn = 1'b1;
        got = obs(); want = sb.pop_front(); vecs++;
        if (got !== want) begin errs++; $display("FAIL %s clear: got %b want %b", name, got, want); end
    endtask
    task automatic test_reset();
        resetn = 1'b0;
        drive(1, 1, 1, 1, 0, 0);
        sb.push_back(4'b0000);
        tick();
        tick();
        got = obs(); want = sb.pop_front(); vecs++;
        if (got !== want) begin errs++; $display("FAIL reset: got %b want %b", got, want); end
        resetn = 1'b1;
        sb.push_back(4'b0000);
        tick();
        got = obs(); want = sb.pop_front(); vecs++;
        if (got !== want) begin errs++; $display("FAIL idle_after_reset: got %b want %b", got, want); end
    endtask
    task automatic test_duty(int lvl);
        cook_from_idle($sformatf("duty_lvl%0d", lvl), lvl, 2 * WIN + 5);
        clear_to_idle("duty");
    endtask
    task automatic test_door();
        cook_from_idle("door_pre", 5, 7);
        bus.door_closed = 1'b0;
        sb.push_back(4'b0100);
        #1;
        got = obs(); want = sb.pop_front(); vecs++;
        if (got !== want) begin errs++; $display("FAIL door_gate: got %b want %b", got, want); end
        for (int i = 0; i < 2; i++) begin
            sb.push_back(4'b0010);
            tick();
            got = obs(); want = sb.pop_front(); vecs++;
            if (got !== want) begin errs++; $display("FAIL door_pause i=%0d: got %b want %b", i, got, want); end
        end
        cook_from_idle("door_resume", 5, 25);
        clear_to_idle("door");
    endtask
    task automatic test_timer();
        cook_from_idle("timer_pre", 10, 5);
        bus.timer_done = 1'b1;
        sb.push_back(4'b0001);
        tick();
        bus.timer_done = 1'b0;
        got = obs(); want = sb.pop_front(); vecs++;
        if (got !== want) begin errs++; $display("FAIL timer_done: got %b want %b", got, want); end
        sb.push_back(4'b0000);
        tick();
        got = obs(); want = sb.pop_front(); vecs++;
        if (got !== want) begin errs++; $display("FAIL done_one_cycle: got %b want %b", got, want); end
        bus.startn = 1'b0;
        bus.timer_done = 1'b1;
        sb.push_back(4'b0000);
        tick();
        bus.startn = 1'b1;
        bus.timer_done = 1'b0;
        got = obs(); want = sb.pop_front(); vecs++;
        if (got !== want) begin errs++; $display("FAIL start_blocked_by_timer: got %b want %b", got, want); end
    endtask
    task automatic test_all_low();
        cook_from_idle("all_low_pre", 10, 3);
        drive(0, 0, 0, 1, 0, 10);
        sb.push_back(4'b0000);
        tick();
        bus.stopn = 1'b1;
        bus.clearn = 1'b1;
        got = obs(); want = sb.pop_front(); vecs++;
        if (got !== want) begin errs++; $display("FAIL all_low_idle: got %b want %b", got, want); end
        sb.push_back(4'b1100);
        tick();
        bus.startn = 1'b1;
        got = obs(); want = sb.pop_front(); vecs++;
        if (got !== want) begin errs++; $display("FAIL held_start_reenter: got %b want %b", got, want); end
        clear_to_idle("all_low");
    endtask
    task automatic test_stop();
        cook_from_idle("stop_pre", 10, 2);
        bus.stopn = 1'b0;
        sb.push_back(4'b0010);
        tick();
        bus.stopn = 1'b1;
        got = obs(); want = sb.pop_front(); vecs++;
        if (got !== want) begin errs++; $display("FAIL stop_pause: got %b want %b", got, want); end
        sb.push_back(4'b0010);
        tick();
        got = obs(); want = sb.pop_front(); vecs++;
        if (got !== want) begin errs++; $display("FAIL pause_hold: got %b want %b", got, want); end
        bus.stopn = 1'b0;
        sb.push_back(4'b0000);
        tick();
        bus.stopn = 1'b1;
        got = obs(); want = sb.pop_front(); vecs++;
        if (got !== want) begin errs++; $display("FAIL pause_stop_idle: got %b want %b", got, want); end
    endtask
    task automatic test_reset_mid();
        cook_from_idle("reset_mid_pre", 10, 3);
        resetn = 1'b0;
        sb.push_back(4'b0000);
        tick();
        resetn = 1'b1;
        got = obs(); want = sb.pop_front(); vecs++;
        if (got !== want) begin errs++; $display("FAIL reset_mid_cook: got %b want %b", got, want); end
        sb.push_back(4'b0000);
        tick();
        got = obs(); want = sb.pop_front(); vecs++;
        if (got !== want) begin errs++; $display("FAIL idle_after_mid_reset: got %b want %b", got, want); end
    endtask
    initial begin
        test_reset();
        test_duty(5);
        test_duty(15);
        test_duty(0);
        test_duty(8);
        test_door();
        test_timer();
        test_all_low();
        test_stop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
